note_arbiter: RTL and testbench
===============================

NOTE_ARBITER -- requirements
Module: note_arbiter

Interface
REQ-001: Parameter DEBOUNCE_CYCLES, default 16, SHALL set consecutive stable cycles needed to accept a switch change (legal range 2..255).
REQ-002: Parameter MIN_HOLD, default 32, SHALL set minimum cycles a note stays enabled once started (legal range 1..1023).
REQ-003: Parameter GAP_CYCLES, default 4, SHALL set silent cycles inserted between any two notes (legal range 1..255).
REQ-004: clk  input  1  SHALL be the single clock; all state updates on its rising edge.
REQ-005: rst  input  1  SHALL be the reset: synchronous, active-high.
REQ-006: sw  input  8  SHALL carry raw, asynchronous key switches; bit0=C, bit1=D, bit2=E, bit3=F, bit4=G, bit5=A, bit6=B, bit7=C2.
REQ-007: en_note  output  8  SHALL be a registered one-hot (or all-zero) note enable, same bit order as sw.
REQ-008: note_idx  output  3  SHALL give the index (0..7) of the enabled note; 0 when no note is enabled.
REQ-009: note_valid  output  1  SHALL be high exactly when en_note is nonzero.
REQ-010: note_start  output  1  SHALL pulse high for one cycle on the first cycle of each new note.

Function
REQ-011: Each sw bit SHALL pass through a 2-flop synchronizer before any other logic.
REQ-012: Each synchronized bit SHALL have its own debouncer: counter increments while synced != debounced, clears to 0 when equal; on the edge where it would reach DEBOUNCE_CYCLES, debounced <= synced and counter <= 0.
REQ-013: A glitch shorter than DEBOUNCE_CYCLES cycles SHALL leave the debounced value unchanged.
REQ-014: Winner SHALL be the lowest-index debounced-pressed key (C highest priority); "none" if all released.
REQ-015: FSM SHALL have states IDLE, PLAY, GAP; all outputs registered from FSM state and latched current note.
REQ-016: IDLE: all outputs 0; if winner exists, latch it as current note, clear hold counter, go to PLAY.
REQ-017: PLAY: en_note = one-hot(current), note_idx = current, note_valid = 1; hold counter increments, saturating at MIN_HOLD.
REQ-018: PLAY SHALL be left only when hold counter == MIN_HOLD and winner != current (including "none"); then go to GAP and clear gap counter.
REQ-019: Release or priority change before MIN_HOLD reached SHALL NOT shorten the note; decision is re-evaluated every cycle after saturation.
REQ-020: A note kept pressed and still the winner SHALL stay in PLAY indefinitely, with no gap and no repeat note_start.
REQ-021: GAP: all outputs 0; after GAP_CYCLES cycles in GAP, go to PLAY with the current winner (latched, hold cleared) or to IDLE if none.
REQ-022: Same key released and re-pressed SHALL still pass through GAP and produce a new note_start.
REQ-023: note_start SHALL be high on the first cycle en_note shows a newly latched note only.
REQ-024: Latency: a clean press from IDLE SHALL assert en_note DEBOUNCE_CYCLES+3 cycles after the first rising edge sampling the new sw level.
REQ-025: Simultaneous debounced presses SHALL resolve per REQ-014 in the same cycle; never more than one en_note bit high.

Reset
REQ-026: While rst is high at a rising edge, FSM <= IDLE; en_note, note_idx, note_valid, note_start <= 0; synchronizers, debounced values and all counters <= 0.
REQ-027: Reset mid-PLAY or mid-GAP SHALL zero outputs on that edge, with no GAP and no note_start emitted for the aborted note.
REQ-028: After rst deasserts, keys held throughout SHALL be treated as new presses and obey REQ-024 latency.

Verification (defaults: DEBOUNCE_CYCLES=16, MIN_HOLD=32, GAP_CYCLES=4)
REQ-029: sw=0x04 held from idle -> en_note=0x04, note_idx=2, note_valid=1, note_start pulse, all exactly 19 cycles after first sampling edge.
REQ-030: sw pulses 0x01 for 10 cycles then 0x00 -> en_note stays 0x00 throughout.
REQ-031: sw=0x10 held 5 cycles after note start then released -> en_note=0x10 for exactly 32 cycles, then 0x00 for 4 cycles, then IDLE with outputs 0.
REQ-032: sw=0x20 playing for 40 cycles, then sw=0x28 -> after debounce, 0x20 drops, 4 gap cycles, en_note=0x08, note_idx=3, note_start pulse.
REQ-033: sw=0xFF from idle -> en_note=0x01, note_idx=0; only one bit high in every cycle.
REQ-034: rst asserted for one cycle during PLAY of 0x80 with sw held -> outputs 0 at that edge; en_note=0x80 re-asserts 19 cycles after rst deasserts, with note_start.

Source files
------------

// File: rtl/note_arbiter_if.sv
// Key-switch input and registered note outputs of the note arbiter.
// The master side drives the switches; the slave side drives the notes.
interface note_arbiter_if;
   logic [7:0] sw;
   logic [7:0] en_note;
   logic [2:0] note_idx;
   logic       note_valid;
   logic       note_start;

   modport master (
      output sw,
      input  en_note,
      input  note_idx,
      input  note_valid,
      input  note_start
   );

   modport slave (
      input  sw,
      output en_note,
      output note_idx,
      output note_valid,
      output note_start
   );
endinterface

// File: rtl/note_arbiter.sv
// Eight-key note arbiter: synchronize, debounce, pick lowest pressed
// key, hold each note a minimum time and separate notes by a gap.
module note_arbiter #(
   parameter int DEBOUNCE_CYCLES = 16,
   parameter int MIN_HOLD        = 32,
   parameter int GAP_CYCLES      = 4
) (
   input  logic       clk,
   input  logic       rst,
   note_arbiter_if.slave bus
);

   typedef enum logic [1:0] {
      IDLE,
      PLAY,
      GAP
   } state_t;

   localparam logic [7:0] DB_LAST =
      8'(DEBOUNCE_CYCLES - 1);
   localparam logic [9:0] HOLD_LAST =
      10'(MIN_HOLD - 1);
   localparam logic [7:0] GAP_LAST =
      8'(GAP_CYCLES - 1);

   state_t     state;
   state_t     state_nxt;
   logic [7:0] s1;
   logic [7:0] s2;
   logic [7:0] deb;
   logic [7:0] cnt [8];
   logic [2:0] cur;
   logic [2:0] cur_nxt;
   logic [9:0] hold;
   logic [9:0] hold_nxt;
   logic [7:0] gap;
   logic [7:0] gap_nxt;
   logic       fresh;
   logic       fresh_nxt;
   logic       win_vld;
   logic [2:0] win_idx;

   always_ff @(posedge clk) begin
      if (rst) begin
         s1  <= '0;
         s2  <= '0;
         deb <= '0;
         for (int i = 0; i < 8; i++)
            cnt[i] <= '0;
      end else begin
         s1 <= bus.sw;
         s2 <= s1;
         for (int i = 0; i < 8; i++) begin
            if (s2[i] != deb[i]) begin
               if (cnt[i] == DB_LAST) begin
                  deb[i] <= s2[i];
                  cnt[i] <= '0;
               end else begin
                  cnt[i] <= cnt[i] + 8'd1;
               end
            end else begin
               cnt[i] <= '0;
            end
         end
      end
   end

   // Scan downward so the lowest pressed index wins.
   always_comb begin
      win_vld = |deb;
      win_idx = '0;
      for (int i = 7; i >= 0; i--)
         if (deb[i])
            win_idx = 3'(i);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state <= IDLE;
         cur   <= '0;
         hold  <= '0;
         gap   <= '0;
         fresh <= 1'b0;
      end else begin
         state <= state_nxt;
         cur   <= cur_nxt;
         hold  <= hold_nxt;
         gap   <= gap_nxt;
         fresh <= fresh_nxt;
      end
   end

   // hold counts PLAY cycles already spent; it saturates one short
   // of MIN_HOLD so the exit lands on the last required cycle.
   always_comb begin
      state_nxt = state;
      cur_nxt   = cur;
      hold_nxt  = hold;
      gap_nxt   = gap;
      fresh_nxt = 1'b0;
      unique case (state)
         IDLE: begin
            if (win_vld) begin
               cur_nxt   = win_idx;
               hold_nxt  = '0;
               fresh_nxt = 1'b1;
               state_nxt = PLAY;
            end
         end
         PLAY: begin
            if (hold != HOLD_LAST) begin
               hold_nxt = hold + 10'd1;
            end else if (!win_vld ||
                         win_idx != cur) begin
               gap_nxt   = '0;
               state_nxt = GAP;
            end
         end
         GAP: begin
            if (gap == GAP_LAST) begin
               if (win_vld) begin
                  cur_nxt   = win_idx;
                  hold_nxt  = '0;
                  fresh_nxt = 1'b1;
                  state_nxt = PLAY;
               end else begin
                  state_nxt = IDLE;
               end
            end else begin
               gap_nxt = gap + 8'd1;
            end
         end
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst || state != PLAY) begin
         bus.en_note    <= '0;
         bus.note_idx   <= '0;
         bus.note_valid <= 1'b0;
         bus.note_start <= 1'b0;
      end else begin
         bus.en_note    <= 8'd1 << cur;
         bus.note_idx   <= cur;
         bus.note_valid <= 1'b1;
         bus.note_start <= fresh;
      end
   end

endmodule

// File: tb/tb_note_arbiter.sv
// Directed bench for note_arbiter: vector table plus
// hand sequences for priority change, all-keys and reset.
module tb_note_arbiter;

   typedef struct {
      string      nm;
      logic       rst;
      logic [7:0] sw;
      int         ticks;
      logic [7:0] en;
      logic [2:0] idx;
      logic       st;
   } vec_t;

   logic clk = 1'b0;
   logic rst = 1'b1;
   int   n_cmp = 0;
   int   n_bad = 0;
   bit   mon_on = 1'b0;
   vec_t tv[$];

   always #5 clk = ~clk;

   note_arbiter_if bus ();

   note_arbiter #(
      .DEBOUNCE_CYCLES(16),
      .MIN_HOLD(32),
      .GAP_CYCLES(4)
   ) dut (
      .clk(clk),
      .rst(rst),
      .bus(bus)
   );

   function automatic vec_t mk(
      string nm, logic r, logic [7:0] sw,
      int t, logic [7:0] en,
      logic [2:0] idx, logic st
   );
      vec_t v;
      v.nm = nm;
      v.rst = r;
      v.sw = sw;
      v.ticks = t;
      v.en = en;
      v.idx = idx;
      v.st = st;
      return v;
   endfunction

   task automatic tick(input int n);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic chk(
      input string nm, input logic [7:0] en,
      input logic [2:0] idx, input logic st
   );
      logic v;
      v = (en != 8'h00);
      n_cmp++;
      if (bus.en_note !== en ||
          bus.note_idx !== idx ||
          bus.note_valid !== v ||
          bus.note_start !== st) begin
         n_bad++;
         $display("FAIL %s: got en=%02h idx=%0d v=%0b st=%0b want en=%02h idx=%0d v=%0b st=%0b",
                  nm, bus.en_note, bus.note_idx,
                  bus.note_valid, bus.note_start,
                  en, idx, v, st);
      end
   endtask

   // A clean press is visible on the 20th tick after sw changes.
   task automatic press(
      input string nm, input logic [7:0] en,
      input logic [2:0] idx
   );
      for (int k = 1; k <= 20; k++) begin
         tick(1);
         if (k < 20)
            chk(nm, 8'h00, 3'd0, 1'b0);
         else
            chk(nm, en, idx, 1'b1);
      end
   endtask

   always @(negedge clk) begin : mon
      logic [2:0] ei;
      if (mon_on) begin
         ei = 3'd0;
         for (int i = 7; i >= 0; i--)
            if (bus.en_note[i])
               ei = 3'(i);
         n_cmp++;
         if ($countones(bus.en_note) > 1 ||
             bus.note_valid !== (bus.en_note != 8'h00) ||
             bus.note_idx !== ei) begin
            n_bad++;
            $display("FAIL onehot: got en=%02h idx=%0d v=%0b want one-hot with idx=%0d",
                     bus.en_note, bus.note_idx,
                     bus.note_valid, ei);
         end
      end
   end

   initial begin
      bus.sw = 8'h00;
      rst = 1'b1;
      tv.push_back(mk("reset",   1, 8'h00,  2, 8'h00, 0, 0));
      tv.push_back(mk("idle",    0, 8'h00,  3, 8'h00, 0, 0));
      tv.push_back(mk("glitch_a",0, 8'h01, 10, 8'h00, 0, 0));
      tv.push_back(mk("glitch_b",0, 8'h00, 15, 8'h00, 0, 0));
      tv.push_back(mk("glitch_c",0, 8'h00, 15, 8'h00, 0, 0));
      tv.push_back(mk("g_pre",   0, 8'h10, 19, 8'h00, 0, 0));
      tv.push_back(mk("g_start", 0, 8'h10,  1, 8'h10, 4, 1));
      tv.push_back(mk("g_play",  0, 8'h10,  1, 8'h10, 4, 0));
      tv.push_back(mk("g_held",  0, 8'h10,  4, 8'h10, 4, 0));
      tv.push_back(mk("g_min_a", 0, 8'h00, 25, 8'h10, 4, 0));
      tv.push_back(mk("g_min_b", 0, 8'h00,  1, 8'h10, 4, 0));
      tv.push_back(mk("g_gap_a", 0, 8'h00,  1, 8'h00, 0, 0));
      tv.push_back(mk("g_gap_b", 0, 8'h00,  3, 8'h00, 0, 0));
      tv.push_back(mk("g_idle",  0, 8'h00, 10, 8'h00, 0, 0));
      tv.push_back(mk("e_pre",   0, 8'h04, 19, 8'h00, 0, 0));
      tv.push_back(mk("e_start", 0, 8'h04,  1, 8'h04, 2, 1));
      tv.push_back(mk("e_play",  0, 8'h04,  1, 8'h04, 2, 0));

      foreach (tv[i]) begin
         rst = tv[i].rst;
         bus.sw = tv[i].sw;
         tick(tv[i].ticks);
         mon_on = 1'b1;
         chk(tv[i].nm, tv[i].en, tv[i].idx, tv[i].st);
      end

      // Reset mid-PLAY, then priority change after hold.
      rst = 1'b1;
      tick(1);
      chk("rst_mid_play", 8'h00, 3'd0, 1'b0);
      rst = 1'b0;
      bus.sw = 8'h20;
      press("a_press", 8'h20, 3'd5);
      tick(40);
      chk("a_hold", 8'h20, 3'd5, 1'b0);
      bus.sw = 8'h28;
      for (int k = 1; k <= 25; k++) begin
         tick(1);
         if (k <= 19)
            chk("a_old", 8'h20, 3'd5, 1'b0);
         else if (k <= 23)
            chk("a_gap", 8'h00, 3'd0, 1'b0);
         else
            chk("a_new", 8'h08, 3'd3, k == 24);
      end

      // All keys at once from a fresh reset.
      rst = 1'b1;
      bus.sw = 8'hFF;
      tick(1);
      chk("b_rst", 8'h00, 3'd0, 1'b0);
      rst = 1'b0;
      press("b_press", 8'h01, 3'd0);
      for (int k = 0; k < 6; k++) begin
         tick(10);
         chk("b_stay", 8'h01, 3'd0, 1'b0);
      end

      // Reset during PLAY of C2 with the key held.
      rst = 1'b1;
      bus.sw = 8'h80;
      tick(1);
      rst = 1'b0;
      press("c_press", 8'h80, 3'd7);
      tick(5);
      chk("c_play", 8'h80, 3'd7, 1'b0);
      rst = 1'b1;
      tick(1);
      chk("c_rst", 8'h00, 3'd0, 1'b0);
      rst = 1'b0;
      press("c_repress", 8'h80, 3'd7);
      tick(1);
      chk("c_after", 8'h80, 3'd7, 1'b0);

      mon_on = 1'b0;
      $display("*** SUMMARY: %0d compared / %0d mismatched ***",
               n_cmp, n_bad);
      $finish;
   end

endmodule
